// File: rtl/button_debouncer_pkg.sv
// Shared defaults and per-button event type for the push-button front end.
package button_debouncer_pkg;

  localparam int DEF_WIDTH           = 3;
  // About 20 ms at the 50 MHz board clock
  localparam int DEF_DEBOUNCE_CYCLES = 1000000;
  localparam bit DEF_ACTIVE_LOW      = 1'b0;

  typedef struct packed {
    logic state;
    logic press;
    logic rel;
  } btn_evt_t;

endpackage

// File: rtl/button_debounce_one.sv
// One button: 2-flop synchronizer, persistence counter, debounced level and edge pulses.
module button_debounce_one
  import button_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     n,
  output btn_evt_t o
);

  localparam int              CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_param
    $error("DEBOUNCE_CYCLES must be at least 2");
  end

  logic [1:0]    sync_pipe;
  logic          s;
  logic          stable;
  logic [CW-1:0] cnt;
  logic          press;
  logic          rel;

  assign s = sync_pipe[1];

  // Any return of s to the stable level restarts the count, so bounces never accumulate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_pipe <= '0;
      stable    <= 1'b0;
      cnt       <= '0;
      press     <= 1'b0;
      rel       <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[0], n};
      press     <= 1'b0;
      rel       <= 1'b0;
      if (s == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stable <= s;
        cnt    <= '0;
        press  <= s;
        rel    <= ~s;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign o = '{state: stable, press: press, rel: rel};

endmodule

// File: rtl/button_debouncer.sv
// Push-button front end: polarity normalization plus one debouncer per button.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int WIDTH           = DEF_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit ACTIVE_LOW      = DEF_ACTIVE_LOW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] btn_raw,
  output logic [WIDTH-1:0] btn_state,
  output logic [WIDTH-1:0] btn_press,
  output logic [WIDTH-1:0] btn_release
);

  logic     [WIDTH-1:0] n;
  btn_evt_t [WIDTH-1:0] evt;

  // After this point 1 always means pressed.
  assign n = btn_raw ^ {WIDTH{ACTIVE_LOW}};

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    button_debounce_one #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_one (
      .clk  (clk),
      .reset(reset),
      .n    (n[i]),
      .o    (evt[i])
    );
    assign btn_state[i]   = evt[i].state;
    assign btn_press[i]   = evt[i].press;
    assign btn_release[i] = evt[i].rel;
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with DEBOUNCE_CYCLES=4, active-high and active-low instances.
module tb_button_debouncer;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] raw, raw2;
  logic [2:0] st, pr, rl;
  logic [2:0] st2, pr2, rl2;

  int n_chk  = 0;
  int n_fail = 0;
  int pc[3];
  int rc[3];
  int both_err = 0;
  int pc0[3];
  int rc0[3];

  always #5 clk = ~clk;

  button_debouncer #(.WIDTH(3), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b0)) u_dut (
    .clk(clk), .reset(reset), .btn_raw(raw),
    .btn_state(st), .btn_press(pr), .btn_release(rl)
  );

  button_debouncer #(.WIDTH(3), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b1)) u_dut_al (
    .clk(clk), .reset(reset), .btn_raw(raw2),
    .btn_state(st2), .btn_press(pr2), .btn_release(rl2)
  );

  initial begin
    for (int b = 0; b < 3; b++) begin
      pc[b] = 0;
      rc[b] = 0;
    end
  end

  // Pulse accounting, sampled away from the active edge
  always @(negedge clk) begin
    for (int b = 0; b < 3; b++) begin
      if (pr[b]) pc[b] = pc[b] + 1;
      if (rl[b]) rc[b] = rc[b] + 1;
    end
    if (((pr & rl) != 3'b000) || ((pr2 & rl2) != 3'b000)) both_err = both_err + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic snap();
    for (int b = 0; b < 3; b++) begin
      pc0[b] = pc[b];
      rc0[b] = rc[b];
    end
  endtask

  initial begin
    logic [5:0] bounce;
    bounce = 6'b101101;   // applied LSB first: 1,0,1,1,0,1

    // Reset
    reset = 1'b1;
    raw   = 3'b000;
    raw2  = 3'b111;
    tick(3);
    chk("rst_state", 32'(st), 32'h0);
    chk("rst_press", 32'(pr), 32'h0);
    chk("rst_rel",   32'(rl), 32'h0);
    chk("rst_state_al", 32'(st2), 32'h0);
    reset = 1'b0;
    snap();
    tick(20);
    chk("idle_state", 32'(st), 32'h0);
    chk("idle_pulses", 32'(pc[0]+pc[1]+pc[2]+rc[0]+rc[1]+rc[2]-pc0[0]-pc0[1]-pc0[2]-rc0[0]-rc0[1]-rc0[2]), 32'h0);
    chk("idle_state_al", 32'(st2), 32'h0);

    // Clean press on bit 0: visible 6 edges after the change
    raw = 3'b001;
    tick(5);
    chk("press0_early_state", 32'(st), 32'h0);
    chk("press0_early_pulse", 32'(pr), 32'h0);
    tick(1);
    chk("press0_state", 32'(st), 32'h1);
    chk("press0_pulse", 32'(pr), 32'h1);
    tick(1);
    chk("press0_pulse_end", 32'(pr), 32'h0);
    chk("press0_hold", 32'(st), 32'h1);

    // Bounce on bit 1, then steady high
    snap();
    for (int i = 0; i < 6; i++) begin
      raw[1] = bounce[i];
      tick(1);
    end
    tick(4);
    chk("bounce_early_pulse", 32'(pr), 32'h0);
    chk("bounce_early_state", 32'(st), 32'h1);
    tick(1);
    chk("bounce_pulse", 32'(pr), 32'h2);
    chk("bounce_state", 32'(st), 32'h3);
    tick(1);
    chk("bounce_pulse_end", 32'(pr), 32'h0);
    chk("bounce_press_cnt", 32'(pc[1]-pc0[1]), 32'h1);
    chk("bounce_rel_cnt", 32'(rc[1]-rc0[1]), 32'h0);

    // 3-cycle glitch on bit 2 is rejected
    snap();
    raw[2] = 1'b1;
    tick(3);
    raw[2] = 1'b0;
    tick(10);
    chk("glitch_state", 32'(st), 32'h3);
    chk("glitch_pulses", 32'(pc[2]-pc0[2]+rc[2]-rc0[2]), 32'h0);

    // A 4-cycle pulse is exactly long enough to be accepted, then released
    snap();
    raw[2] = 1'b1;
    tick(4);
    raw[2] = 1'b0;
    tick(12);
    chk("min_pulse_press", 32'(pc[2]-pc0[2]), 32'h1);
    chk("min_pulse_rel",   32'(rc[2]-rc0[2]), 32'h1);
    chk("min_pulse_state", 32'(st), 32'h3);

    // Simultaneous release of bits 0 and 1
    raw = 3'b000;
    tick(5);
    chk("rel_early_state", 32'(st), 32'h3);
    tick(1);
    chk("rel_pulse", 32'(rl), 32'h3);
    chk("rel_state", 32'(st), 32'h0);
    chk("rel_no_press", 32'(pr), 32'h0);
    tick(1);
    chk("rel_pulse_end", 32'(rl), 32'h0);

    // Reset while bit 0 is mid-count, button held through reset release
    snap();
    raw = 3'b001;
    tick(4);
    reset = 1'b1;
    #1;
    chk("midrst_state", 32'(st), 32'h0);
    tick(2);
    chk("midrst_pulses", 32'({pr, rl}), 32'h0);
    reset = 1'b0;
    tick(5);
    chk("postrst_early", 32'({st, pr}), 32'h0);
    tick(1);
    chk("postrst_press", 32'(pr), 32'h1);
    chk("postrst_state", 32'(st), 32'h1);
    chk("postrst_no_rel", 32'(rc[0]+rc[1]+rc[2]-rc0[0]-rc0[1]-rc0[2]), 32'h0);

    // Active-low instance: pin 1->0 is a press, 0->1 a release
    raw2 = 3'b110;
    tick(5);
    chk("al_early_state", 32'(st2), 32'h0);
    tick(1);
    chk("al_press", 32'(pr2), 32'h1);
    chk("al_state", 32'(st2), 32'h1);
    raw2 = 3'b111;
    tick(6);
    chk("al_release", 32'(rl2), 32'h1);
    chk("al_rel_state", 32'(st2), 32'h0);

    chk("never_both", 32'(both_err), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
